cic_mc_decimator: RTL and testbench

CIC_MC_DECIMATOR -- requirements
Module: cic_mc_decimator

---
 rtl/cic_mc_decimator_pkg.sv | 40 ++++
 rtl/cic_mc_decimator_if.sv | 45 ++++
 rtl/cic_mc_decimator_comb.sv | 106 ++++++++++
 rtl/cic_mc_decimator.sv | 122 ++++++++++++
 tb/tb_cic_mc_decimator.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_mc_decimator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cic_pkg
//  Purpose  : Shared constants and width helpers for the multichannel CIC
//             decimator (accumulator width, channel-pointer width, rate and
//             phase-counter widths, default parameter values).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_STAGES   = 3;
    localparam int DEF_LOG2_MAX = 4;
    localparam int DEF_NCH      = 2;

    // Worst-case CIC gain is R^S = 2^(S*log2R); the accumulators need that
    // many extra bits on top of the sample width so the final comb output
    // is exact even though the integrators wrap.
    function automatic int acc_width(input int width, input int stages, input int log2_max);
        return width + stages * log2_max;
    endfunction

    // Channel pointer / out_ch width, never below one bit.
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Width of the rate_log2 field (holds 0..log2_max).
    function automatic int rate_width(input int log2_max);
        return (log2_max > 0) ? $clog2(log2_max + 1) : 1;
    endfunction

    // Phase counter width: counts 0..2^log2_max-1.
    function automatic int phase_width(input int log2_max);
        return (log2_max > 0) ? log2_max : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_mc_decimator_if.sv
`default_nettype none
// ============================================================================
//  Module   : cic_mc_decimator_if
//  Purpose  : Configuration plus input/output stream handshake bundle of the
//             multichannel CIC decimator.
//  Signals  : cfg_load/rate_log2 - rate capture and flush
//             in_data/in_valid/in_ready - input sample stream
//             out_data/out_ch/out_valid/out_ready - decimated output stream
//  Modports : master - stream source / sink side (testbench, upstream logic)
//             slave  - decimator side
//  Revision : 1.0 - initial release
// ============================================================================
interface cic_mc_decimator_if
    import cic_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NCH      = DEF_NCH,
    parameter int LOG2_MAX = DEF_LOG2_MAX
) ();

    localparam int c_CH_W   = ch_width(NCH);
    localparam int c_RATE_W = rate_width(LOG2_MAX);

    logic                    cfg_load;
    logic [c_RATE_W-1:0]     rate_log2;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out_data;
    logic [c_CH_W-1:0]       out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output cfg_load, rate_log2, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  cfg_load, rate_log2, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/cic_mc_decimator_comb.sv
`default_nettype none
// ============================================================================
//  Module   : cic_comb_chain
//  Purpose  : Comb section of the multichannel CIC decimator. On each
//             decimation event it runs STAGES differential-delay-1 combs
//             using the per-channel delay storage, scales the result by
//             2^-(STAGES*rate) with truncation and holds it in the output
//             register until the consumer takes it.
//  Ports    : clk, rstn     - clock, async active-low reset
//             flush_i       - clear delays and drop any pending output
//             event_i       - decimation event for channel ch_i
//             ch_i          - channel of the event
//             sample_i      - last integrator value of that channel
//             rate_i        - captured rate_log2
//             out_ready_i   - consumer ready
//             out_data_o/out_ch_o/out_valid_o - registered output
//  Revision : 1.0 - initial release
// ============================================================================
module cic_comb_chain
    import cic_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STAGES   = DEF_STAGES,
    parameter int LOG2_MAX = DEF_LOG2_MAX,
    parameter int NCH      = DEF_NCH,
    parameter int ACC_W    = acc_width(WIDTH, STAGES, LOG2_MAX)
) (
    input  wire logic                                clk,
    input  wire logic                                rstn,
    input  wire logic                                flush_i,
    input  wire logic                                event_i,
    input  wire logic [ch_width(NCH)-1:0]            ch_i,
    input  wire logic signed [ACC_W-1:0]             sample_i,
    input  wire logic [rate_width(LOG2_MAX)-1:0]     rate_i,
    input  wire logic                                out_ready_i,
    output logic signed [WIDTH-1:0]                  out_data_o,
    output logic [ch_width(NCH)-1:0]                 out_ch_o,
    output logic                                     out_valid_o
);

    localparam int c_CH_W = ch_width(NCH);

    logic signed [ACC_W-1:0] dly_q [NCH][STAGES];
    logic signed [WIDTH-1:0] out_data_q;
    logic [c_CH_W-1:0]       out_ch_q;
    logic                    out_valid_q;

    logic signed [ACC_W-1:0] w_stage_in [STAGES];
    logic signed [ACC_W-1:0] w_result;
    logic signed [WIDTH-1:0] w_scaled;
    int                      w_shift;

    // Comb chain for the event channel; w_stage_in[k] is C_(k-1), which is
    // also what the delay of stage k must remember.
    always_comb begin
        logic signed [ACC_W-1:0] v_c;
        v_c = sample_i;
        for (int k = 0; k < STAGES; k++) begin
            w_stage_in[k] = v_c;
            v_c           = v_c - dly_q[ch_i][k];
        end
        w_result = v_c;
        w_shift  = STAGES * int'(rate_i);
        // Arithmetic shift removes the R^S gain, then keep the low bits.
        w_scaled = WIDTH'(w_result >>> w_shift);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (event_i) begin
            // An event is only possible when the output slot is free or
            // being consumed this cycle, so overwriting is always safe.
            for (int k = 0; k < STAGES; k++) begin
                dly_q[ch_i][k] <= w_stage_in[k];
            end
            out_data_q  <= w_scaled;
            out_ch_q    <= ch_i;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: rtl/cic_mc_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : cic_mc_decimator
//  Purpose  : Multichannel (round-robin interleaved) CIC decimator with
//             run-time power-of-two rate. Holds the integrator bank, the
//             per-channel phase counters and the channel pointer; the comb
//             section lives in cic_comb_chain.
//  Ports    : clk  - clock, all state on rising edge
//             rstn - asynchronous active-low reset
//             bus  - cic_mc_decimator_if.slave (config + in/out handshakes)
//  Revision : 1.0 - initial release
// ============================================================================
module cic_mc_decimator
    import cic_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STAGES   = DEF_STAGES,
    parameter int LOG2_MAX = DEF_LOG2_MAX,
    parameter int NCH      = DEF_NCH
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    cic_mc_decimator_if.slave bus
);

    localparam int ACC_W    = acc_width(WIDTH, STAGES, LOG2_MAX);
    localparam int c_CH_W   = ch_width(NCH);
    localparam int c_RATE_W = rate_width(LOG2_MAX);
    localparam int c_PH_W   = phase_width(LOG2_MAX);
    localparam logic [c_PH_W-1:0] c_PH_ONES = '1;

    logic [c_RATE_W-1:0]     rate_q;
    logic [c_CH_W-1:0]       ptr_q;
    logic [c_PH_W-1:0]       phase_q [NCH];
    logic signed [ACC_W-1:0] integ_q [NCH][STAGES];
    logic signed [ACC_W-1:0] integ_d [STAGES];

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_event;
    logic [c_PH_W-1:0]       w_last_phase;
    logic [c_RATE_W-1:0]     w_rate_clamped;
    logic signed [WIDTH-1:0] w_out_data;
    logic [c_CH_W-1:0]       w_out_ch;
    logic                    w_out_valid;

    always_comb begin
        logic signed [ACC_W-1:0] v_sum;
        // Room for a new sample whenever the output slot frees this cycle.
        w_in_ready = rstn && !bus.cfg_load && (!w_out_valid || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;

        // R-1 as a mask of rate_q ones.
        w_last_phase = c_PH_ONES >> (c_PH_W - int'(rate_q));
        w_event      = w_accept && (phase_q[ptr_q] == w_last_phase);

        w_rate_clamped = (int'(bus.rate_log2) > LOG2_MAX) ? c_RATE_W'(LOG2_MAX)
                                                           : bus.rate_log2;

        // Integrator cascade of the current channel, all stages in one cycle.
        v_sum = {{(ACC_W-WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
        for (int k = 0; k < STAGES; k++) begin
            v_sum      = integ_q[ptr_q][k] + v_sum;
            integ_d[k] = v_sum;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rate_q <= '0;
            ptr_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                phase_q[c] <= '0;
                for (int k = 0; k < STAGES; k++) begin
                    integ_q[c][k] <= '0;
                end
            end
        end else if (bus.cfg_load) begin
            rate_q <= w_rate_clamped;
            ptr_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                phase_q[c] <= '0;
                for (int k = 0; k < STAGES; k++) begin
                    integ_q[c][k] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[ptr_q][k] <= integ_d[k];
            end
            phase_q[ptr_q] <= w_event ? '0 : phase_q[ptr_q] + 1'b1;
            ptr_q          <= (ptr_q == c_CH_W'(NCH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    cic_comb_chain #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .LOG2_MAX (LOG2_MAX),
        .NCH      (NCH),
        .ACC_W    (ACC_W)
    ) u_comb (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (bus.cfg_load),
        .event_i     (w_event),
        .ch_i        (ptr_q),
        .sample_i    (integ_d[STAGES-1]),
        .rate_i      (rate_q),
        .out_ready_i (bus.out_ready),
        .out_data_o  (w_out_data),
        .out_ch_o    (w_out_ch),
        .out_valid_o (w_out_valid)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = w_out_data;
    assign bus.out_ch    = w_out_ch;
    assign bus.out_valid = w_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cic_mc_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_mc_decimator
//  Purpose  : Self-checking bench for cic_mc_decimator. Two instances
//             (NCH=1 and NCH=2, STAGES=3, LOG2_MAX=4) share config and
//             out_ready; each has its own in_valid. A convolution model
//             (boxcar(R) convolved STAGES times) predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cic_mc_decimator;

    localparam int WIDTH    = 16;
    localparam int STAGES   = 3;
    localparam int LOG2_MAX = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic                    cfg_load  = 1'b0;
    logic [2:0]              rate_log2 = 3'd0;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] in_data   = '0;
    logic                    vin0      = 1'b0;
    logic                    vin1      = 1'b0;

    cic_mc_decimator_if #(.WIDTH(WIDTH), .NCH(1), .LOG2_MAX(LOG2_MAX)) if0 ();
    cic_mc_decimator_if #(.WIDTH(WIDTH), .NCH(2), .LOG2_MAX(LOG2_MAX)) if1 ();

    assign if0.cfg_load  = cfg_load;
    assign if0.rate_log2 = rate_log2;
    assign if0.in_data   = in_data;
    assign if0.in_valid  = vin0;
    assign if0.out_ready = out_ready;
    assign if1.cfg_load  = cfg_load;
    assign if1.rate_log2 = rate_log2;
    assign if1.in_data   = in_data;
    assign if1.in_valid  = vin1;
    assign if1.out_ready = out_ready;

    cic_mc_decimator #(.WIDTH(WIDTH), .STAGES(STAGES), .LOG2_MAX(LOG2_MAX), .NCH(1))
        dut0 (.clk(clk), .rstn(rstn), .bus(if0));
    cic_mc_decimator #(.WIDTH(WIDTH), .STAGES(STAGES), .LOG2_MAX(LOG2_MAX), .NCH(2))
        dut1 (.clk(clk), .rstn(rstn), .bus(if1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_nch [2] = '{1, 2};
    int m_rate[2];
    int m_ptr [2];
    int m_phase[2][8];
    int hist [2][8][$];
    bit m_valid[2];
    int m_data [2];
    int m_ch   [2];
    int obs_d[2][$];
    int obs_c[2][$];

    function automatic void m_clear(input int d);
        m_ptr[d]   = 0;
        m_valid[d] = 1'b0;
        m_data[d]  = 0;
        m_ch[d]    = 0;
        for (int c = 0; c < 8; c++) begin
            m_phase[d][c] = 0;
            hist[d][c].delete();
        end
    endfunction

    // Output of an S-stage, rate-R CIC = input history convolved with
    // boxcar(R)^*S, divided by R^S with truncation toward -inf.
    function automatic int cic_expect(input int d, input int c);
        int r;
        int h[64];
        int t[64];
        int len;
        int n;
        longint acc;
        longint y;
        logic signed [15:0] lo;
        r   = 1 << m_rate[d];
        len = 1;
        acc = 0;
        for (int i = 0; i < 64; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < 64; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            len += r - 1;
            h = t;
        end
        n = hist[d][c].size();
        for (int k = 0; k < len && k < n; k++)
            acc += longint'(h[k]) * longint'(hist[d][c][n-1-k]);
        y  = acc >>> (STAGES * m_rate[d]);
        lo = y[15:0];
        return int'(lo);
    endfunction

    // Compare DUT against model, then advance model for the next edge.
    always @(negedge clk) begin : cmp
        int a_v, a_d, a_c, a_r, vi, exp_ir, c;
        bit fo;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                a_v = int'(if0.out_valid); a_d = int'(if0.out_data);
                a_c = int'(if0.out_ch);    a_r = int'(if0.in_ready); vi = int'(vin0);
            end else begin
                a_v = int'(if1.out_valid); a_d = int'(if1.out_data);
                a_c = int'(if1.out_ch);    a_r = int'(if1.in_ready); vi = int'(vin1);
            end
            if (!rstn) begin
                m_clear(d);
                m_rate[d] = 0;
            end
            chk($sformatf("out_valid[%0d]", d), a_v, int'(m_valid[d]));
            if (m_valid[d]) begin
                chk($sformatf("out_data[%0d]", d), a_d, m_data[d]);
                chk($sformatf("out_ch[%0d]", d), a_c, m_ch[d]);
            end else if (!rstn) begin
                chk($sformatf("rst_data[%0d]", d), a_d, 0);
                chk($sformatf("rst_ch[%0d]", d), a_c, 0);
            end
            exp_ir = int'(rstn && !cfg_load && (!m_valid[d] || out_ready));
            chk($sformatf("in_ready[%0d]", d), a_r, exp_ir);
            if (rstn && a_v != 0 && out_ready) begin
                obs_d[d].push_back(a_d);
                obs_c[d].push_back(a_c);
            end
            if (rstn) begin
                fo = m_valid[d] && out_ready;
                if (cfg_load) begin
                    m_clear(d);
                    m_rate[d] = (int'(rate_log2) > LOG2_MAX) ? LOG2_MAX : int'(rate_log2);
                end else begin
                    if (fo) m_valid[d] = 1'b0;
                    if (vi != 0 && exp_ir != 0) begin
                        c = m_ptr[d];
                        hist[d][c].push_back(int'(in_data));
                        if (hist[d][c].size() > 64) void'(hist[d][c].pop_front());
                        m_phase[d][c]++;
                        if (m_phase[d][c] == (1 << m_rate[d])) begin
                            m_phase[d][c] = 0;
                            m_valid[d]    = 1'b1;
                            m_data[d]     = cic_expect(d, c);
                            m_ch[d]       = c;
                        end
                        m_ptr[d] = (c + 1) % m_nch[d];
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int obs_at(input int d, input int i);
        if (i < obs_d[d].size()) return obs_d[d][i];
        return -100000;
    endfunction

    function automatic int obs_ch_at(input int d, input int i);
        if (i < obs_c[d].size()) return obs_c[d][i];
        return -100000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int r);
        cfg_load  = 1'b1;
        rate_log2 = 3'(r);
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic send(input int d, input int x);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_data = 16'(x);
        if (d == 0) vin0 = 1'b1; else vin1 = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (d == 0) ? if0.in_ready : if1.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        vin0 = 1'b0;
        vin1 = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int e_d[8];
        int e_c[8];
        int v;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Rate 0 after reset: pass-through, first accept right away
        send(0, 5); send(0, -7); send(0, 32767); send(0, -32768);
        send(1, 300); send(1, -300);
        repeat (3) tick();
        chk("r0_count", obs_d[0].size(), 4);
        chk("r0_o0", obs_at(0, 0), 5);
        chk("r0_o1", obs_at(0, 1), -7);
        chk("r0_o2", obs_at(0, 2), 32767);
        chk("r0_o3", obs_at(0, 3), -32768);
        chk("r0_ch1", obs_ch_at(1, 1), 1);
        chk("r0_d1", obs_at(1, 1), -300);

        // Impulse, R=4
        obs_d[0].delete(); obs_c[0].delete();
        cfg(2);
        send(0, 64);
        repeat (15) send(0, 0);
        repeat (3) tick();
        chk("imp_count", obs_d[0].size(), 4);
        chk("imp_o0", obs_at(0, 0), 10);
        chk("imp_o1", obs_at(0, 1), 6);
        chk("imp_o2", obs_at(0, 2), 0);
        chk("imp_o3", obs_at(0, 3), 0);

        // Step of 100, R=4: 31, 93, then 100
        obs_d[0].delete(); obs_c[0].delete();
        cfg(2);
        repeat (24) send(0, 100);
        repeat (3) tick();
        chk("dc_count", obs_d[0].size(), 6);
        chk("dc_o0", obs_at(0, 0), 31);
        chk("dc_o1", obs_at(0, 1), 93);
        for (int i = 2; i < 6; i++) chk($sformatf("dc_o%0d", i), obs_at(0, i), 100);

        // Two channels, R=2: ch0 50, ch1 -20
        obs_d[1].delete(); obs_c[1].delete();
        cfg(1);
        for (int i = 0; i < 16; i++) send(1, (i % 2 == 0) ? 50 : -20);
        repeat (3) tick();
        e_d = '{25, -10, 50, -20, 50, -20, 50, -20};
        e_c = '{0, 1, 0, 1, 0, 1, 0, 1};
        chk("mc_count", obs_d[1].size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mc_d%0d", i), obs_at(1, i), e_d[i]);
            chk($sformatf("mc_c%0d", i), obs_ch_at(1, i), e_c[i]);
        end

        // Backpressure for 10 cycles at rate 0
        cfg(0);
        obs_d[0].delete(); obs_c[0].delete();
        out_ready = 1'b0;
        send(0, 11);
        fork
            send(0, 22);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(if0.in_ready), 0);
                    chk("stall_data", int'(if0.out_data), 11);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        chk("stall_count", obs_d[0].size(), 2);
        chk("stall_o0", obs_at(0, 0), 11);
        chk("stall_o1", obs_at(0, 1), 22);

        // cfg_load mid-stream with pending output, then clamped rate
        cfg(3);
        out_ready = 1'b0;
        repeat (8) send(0, 1000);
        @(negedge clk);
        chk("pend_valid", int'(if0.out_valid), 1);
        @(posedge clk);
        #1;
        cfg(7);
        @(negedge clk);
        chk("flush_valid", int'(if0.out_valid), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        obs_d[0].delete(); obs_c[0].delete();
        for (int i = 1; i <= 16; i++) begin
            send(0, 1000);
            @(negedge clk);
            v = int'(if0.out_valid);
            if (i == 15) chk("clamp_no_out_15", v, 0);
            if (i == 16) chk("clamp_out_16", v, 1);
            @(posedge clk);
            #1;
        end
        chk("clamp_o0", obs_at(0, 0), 199);

        // Asynchronous reset with a pending output
        cfg(2);
        out_ready = 1'b0;
        send(0, 64);
        repeat (3) send(0, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("async_rst_valid", int'(if0.out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        obs_d[0].delete(); obs_c[0].delete();
        cfg(2);
        send(0, 64);
        repeat (15) send(0, 0);
        repeat (3) tick();
        chk("rst_imp_count", obs_d[0].size(), 4);
        chk("rst_imp_o0", obs_at(0, 0), 10);
        chk("rst_imp_o1", obs_at(0, 1), 6);
        chk("rst_imp_o2", obs_at(0, 2), 0);
        chk("rst_imp_o3", obs_at(0, 3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
